// File: rtl/cache_control.sv
// rtl/cache_control.sv - direct-mapped, write-back cache controller (compare / writeback / allocate)
module cache_control #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [15:0]       mem_address,
    input  logic [TAG_W-1:0]  tag_out,
    input  logic              pmem_resp,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic              pmem_addr_sel,
    output logic              data_write,
    output logic              tag_write,
    output logic              data_sel
);

    localparam int SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_COMPARE   = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [SETS-1:0]     r_valid;
    logic [SETS-1:0]     r_dirty;

    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    logic                w_req;
    logic                w_hit;
    logic                w_unused_offset;

    assign w_index         = mem_address[4 +: INDEX_W];
    assign w_tag           = mem_address[15 -: TAG_W];
    assign w_req           = mem_read | mem_write;
    assign w_hit           = (r_state == S_COMPARE) && r_valid[w_index] && (tag_out == w_tag);
    assign w_unused_offset = ^mem_address[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COMPARE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            case (r_state)
                S_COMPARE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (mem_write)
                                r_dirty[w_index] <= 1'b1;
                        end else if (r_dirty[w_index]) begin
                            r_state <= S_WRITEBACK;
                        end else begin
                            r_state <= S_ALLOCATE;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (pmem_resp) begin
                        r_dirty[w_index] <= 1'b0;
                        r_state          <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    // The fresh line is clean; a pending write dirties it on the retried hit.
                    if (pmem_resp) begin
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                        r_state          <= S_COMPARE;
                    end
                end
                default: r_state <= S_COMPARE;
            endcase
        end
    end

    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        data_write    = 1'b0;
        tag_write     = 1'b0;
        data_sel      = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_COMPARE: begin
                    if (w_req && w_hit) begin
                        mem_resp = 1'b1;
                        if (mem_write) begin
                            data_write = 1'b1;
                            data_sel   = 1'b1;
                        end
                    end
                end
                S_WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                end
                S_ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        data_write = 1'b1;
                        tag_write  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - scoreboard bench for cache_control with a set-level cache model
module tb_cache_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_address = 16'h0;
    logic [8:0]  tag_out;
    logic        pmem_resp = 1'b0;
    logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel;
    logic        data_write, tag_write, data_sel;

    cache_control #(.INDEX_W(3), .TAG_W(9)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .tag_out(tag_out), .pmem_resp(pmem_resp),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel), .data_write(data_write), .tag_write(tag_write),
        .data_sel(data_sel)
    );

    always #5 clk = ~clk;

    // Environment tag array: combinational read, written on tag_write.
    logic [8:0] tb_tags [8];
    initial for (int i = 0; i < 8; i++) tb_tags[i] = '0;
    always @(posedge clk) if (tag_write) tb_tags[mem_address[6:4]] <= mem_address[15:7];
    assign tag_out = tb_tags[mem_address[6:4]];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: what the cache holds, per set.
    bit       m_valid [8];
    bit       m_dirty [8];
    bit [8:0] m_tag   [8];

    typedef struct {
        int issue;
        int lat;
        int wb;
        int al;
        bit wr;
    } exp_t;
    exp_t exp_q [$];

    // Physical memory: answers after a programmed number of request cycles.
    int wb_len = 1;
    int al_len = 1;
    bit spur   = 1'b0;
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (pmem_resp) cnt = 0;
            pmem_resp = spur;
            if (pmem_write || pmem_read) begin
                cnt++;
                if (cnt == (pmem_write ? wb_len : al_len)) pmem_resp = 1'b1;
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: rule checks every cycle, scoreboard pop on every mem_resp.
    int wb_seen = 0;
    int al_seen = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            assert (!(pmem_read && pmem_write));
            assert (!(mem_resp && (pmem_read || pmem_write)));
            chk("pmem_exclusive", int'(pmem_read & pmem_write), 0);
            if (pmem_write) begin
                wb_seen++;
                chk("wb_addr_sel", int'(pmem_addr_sel), 1);
            end
            if (pmem_read) begin
                al_seen++;
                chk("fill_addr_sel", int'(pmem_addr_sel), 0);
            end
            if (pmem_read && pmem_resp)
                chk("fill_enables", int'({data_write, tag_write, data_sel}), 6);
            if (!mem_resp && !(pmem_read && pmem_resp))
                chk("stray_write", int'(data_write | tag_write), 0);
            if (mem_resp) begin
                chk("resp_outside_compare", int'(pmem_read | pmem_write), 0);
                if (exp_q.size() == 0) begin
                    chk("spurious_resp", int'(mem_resp), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc - e.issue + 1, e.lat);
                    chk("resp_data_write", int'(data_write), int'(e.wr));
                    chk("resp_data_sel", int'(data_sel), int'(e.wr));
                    chk("resp_tag_write", int'(tag_write), 0);
                    chk("wb_cycles", wb_seen, e.wb);
                    chk("fill_cycles", al_seen, e.al);
                end
                wb_seen = 0;
                al_seen = 0;
            end else if (!mem_read && !mem_write && !pmem_read && !pmem_write) begin
                wb_seen = 0;
                al_seen = 0;
            end
        end else begin
            chk("reset_outputs", int'({mem_resp, pmem_read, pmem_write, pmem_addr_sel,
                                       data_write, tag_write, data_sel}), 0);
            wb_seen = 0;
            al_seen = 0;
        end
    end

    // Model update for one request; returns the expected response.
    function automatic exp_t model_access(input logic [15:0] a, input bit is_w,
                                          input int wbn, input int aln);
        exp_t e;
        int idx = int'(a[6:4]);
        bit [8:0] tg = a[15:7];
        e.wr = is_w;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            e.lat = 1; e.wb = 0; e.al = 0;
        end else begin
            e.wb  = m_dirty[idx] ? wbn : 0;
            e.al  = aln;
            e.lat = 2 + aln + e.wb;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (is_w) m_dirty[idx] = 1'b1;
        return e;
    endfunction

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_req(input logic [15:0] a, input bit rd, input bit wr,
                          input int wbn, input int aln);
        exp_t e;
        bit got = 1'b0;
        e = model_access(a, wr, wbn, aln);
        wb_len = wbn;
        al_len = aln;
        mem_address = a;
        mem_read    = rd;
        mem_write   = wr;
        e.issue = cyc;
        exp_q.push_back(e);
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = mem_resp;
        end
        if (!got) begin
            chk("resp_timeout", int'(got), 1);
            exp_q.delete();
        end
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        exp_t     e;
        bit       saw_rd, saw_wb, done;
        logic [15:0] a;
        int       op;

        for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; end

        // Request held during reset must produce nothing.
        mem_address = 16'h1230;
        mem_read    = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_read = 1'b0;
        rst_n = 1'b1;

        do_req(16'h1230, 1, 0, 1, 4);      // cold read miss, fill answered in cycle 5
        do_req(16'h1232, 0, 1, 1, 1);      // write hit, dirties set 3
        do_req(16'h5230, 1, 0, 3, 2);      // conflict on dirty set 3: writeback then fill
        do_req(16'h1230, 1, 0, 2, 1);      // set 3 is clean again: no writeback
        do_req(16'h1234, 1, 1, 1, 1);      // read+write on hit behaves as a write

        // Stray pmem_resp while idle is ignored.
        spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        @(negedge clk);
        chk("spur_idle", int'({mem_resp, pmem_read, pmem_write, data_write, tag_write}), 0);
        @(posedge clk); #1;
        do_req(16'h1236, 1, 0, 1, 1);      // still a hit after the stray response

        // Request dropped mid-writeback: transfer still completes.
        saw_wb = m_dirty[3];
        e = model_access(16'h7230, 1'b0, 3, 3);
        wb_len = 3; al_len = 3;
        mem_address = 16'h7230;
        mem_read = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_read = 1'b0;
        saw_rd = 0; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (pmem_read) saw_rd = 1;
            if (saw_rd && !pmem_read && !pmem_write) done = 1;
        end
        chk("drop_completes", int'(done), 1);
        chk("drop_was_dirty", int'(saw_wb), 1);
        @(posedge clk); #1;
        do_req(16'h7230, 1, 0, 1, 1);      // line arrived despite drop: hit

        // Reset pulse mid-allocate.
        al_len = 10;
        mem_address = 16'h2340;
        mem_read = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        mem_read = 1'b0;
        #1 chk("reset_drops_pmem_read", int'(pmem_read), 0);
        for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        @(posedge clk); #1 rst_n = 1'b1;
        do_req(16'h2340, 1, 0, 1, 2);      // must miss again
        do_req(16'h1230, 1, 0, 1, 1);      // every set invalid after reset

        // Randomized traffic over a few tags so hits, clean and dirty misses all occur.
        for (int n = 0; n < 150; n++) begin
            a  = {7'h10 + 7'($urandom_range(0, 2)), 2'b00, 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15))};
            op = $urandom_range(0, 2);
            do_req(a, op != 1, op != 0, $urandom_range(1, 4), $urandom_range(1, 4));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
